// File: rtl/ysyx_24100005_ifu_if.sv
// Instruction-memory port of the fetch unit.
//
// Handshake rules for this bus:
//   - A request transfers on a rising clock edge where req_valid && req_ready.
//     Once req_valid is raised, req_valid and addr hold until that edge.
//   - Exactly one response (rsp_valid high for one cycle, with rsp_data and
//     rsp_err) follows each transferred request, no earlier than the cycle
//     after the transfer. rsp_valid has no ready; the fetch unit always takes it.
//
// Signals:
//   req_valid  master -> slave  request pending
//   req_ready  slave  -> master memory accepts the request
//   addr       master -> slave  word-aligned fetch address
//   rsp_valid  slave  -> master response valid
//   rsp_data   slave  -> master instruction word
//   rsp_err    slave  -> master bus error on this response
interface ysyx_24100005_ifu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] addr;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_err;

    modport master (
        output req_valid,
        output addr,
        input  req_ready,
        input  rsp_valid,
        input  rsp_data,
        input  rsp_err
    );

    modport slave (
        input  req_valid,
        input  addr,
        output req_ready,
        output rsp_valid,
        output rsp_data,
        output rsp_err
    );
endinterface

// File: rtl/ysyx_24100005_ifu.sv
// Instruction fetch unit.
//
// Takes the PC from the core, issues a single request on the instruction
// memory port, captures the response and presents it to the core with a
// valid/ready handshake. Misaligned PCs and memory errors are delivered as a
// fault (inst_err=1, inst=0) instead of an instruction.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   pc, pc_valid      fetch request from the core
//   flush             redirect: discard any in-flight or held fetch
//   inst, inst_err    delivered instruction / fault flag, valid with inst_valid
//   inst_valid        held high until inst_ready (or flush)
//   inst_ready        core consumes inst in this cycle
//   imem              instruction-memory port (master side)
//   fetch_cnt         number of deliveries taken by the core (wraps)
//   state_dbg         current FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 HOLD
//
// Core-side handshake: a delivery is taken on a rising edge where
// inst_valid && inst_ready && !flush; inst and inst_err hold while
// inst_valid is high.
//
// All outputs are decoded from registers only; no input reaches an output
// combinationally.
module ysyx_24100005_ifu #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   pc,
    input  logic                pc_valid,
    input  logic                flush,
    output logic [DATA_W-1:0]   inst,
    output logic                inst_valid,
    input  logic                inst_ready,
    output logic                inst_err,
    ysyx_24100005_ifu_if.master imem,
    output logic [CNT_W-1:0]    fetch_cnt,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] inst_q,  inst_d;
    logic              err_q,   err_d;
    logic              drop_q,  drop_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            inst_q  <= '0;
            err_q   <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        inst_d  = inst_q;
        err_d   = err_q;
        drop_d  = drop_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                // A flush in the same cycle cancels the request outright.
                if (pc_valid && !flush) begin
                    if (pc[1:0] == 2'b00) begin
                        addr_d  = {pc[ADDR_W-1:2], 2'b00};
                        state_d = S_REQ;
                    end else begin
                        // Misaligned: report a fault without touching memory.
                        inst_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_HOLD;
                    end
                end
            end

            S_REQ: begin
                // The request is never withdrawn once raised; a flush only
                // marks its response to be thrown away.
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (imem.req_ready) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                if (imem.rsp_valid) begin
                    if (drop_q || flush) begin
                        drop_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        inst_d  = imem.rsp_err ? '0 : imem.rsp_data;
                        err_d   = imem.rsp_err;
                        state_d = S_HOLD;
                    end
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end

            S_HOLD: begin
                // Flush wins over inst_ready: the delivery is not counted.
                if (flush) begin
                    state_d = S_IDLE;
                end else if (inst_ready) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign inst           = inst_q;
    assign inst_err       = err_q;
    assign inst_valid     = (state_q == S_HOLD);
    assign imem.req_valid = (state_q == S_REQ);
    assign imem.addr      = addr_q;
    assign fetch_cnt      = cnt_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_ysyx_24100005_ifu.sv
module tb_ysyx_24100005_ifu;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 32;
    localparam int NO_FLUSH = 1000;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [ADDR_W-1:0] pc;
    logic              pc_valid;
    logic              flush;
    logic [DATA_W-1:0] inst;
    logic              inst_valid;
    logic              inst_ready;
    logic              inst_err;
    logic [CNT_W-1:0]  fetch_cnt;
    logic [1:0]        state_dbg;

    ysyx_24100005_ifu_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) imem ();

    ysyx_24100005_ifu #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .inst       (inst),
        .inst_valid (inst_valid),
        .inst_ready (inst_ready),
        .inst_err   (inst_err),
        .imem       (imem),
        .fetch_cnt  (fetch_cnt),
        .state_dbg  (state_dbg)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference memory contents ----------------
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h0F0F_1234;
    endfunction

    function automatic logic mem_err(input logic [31:0] a);
        return (a[5:2] == 4'h1);
    endfunction

    // ---------------- memory responder ----------------
    int          mem_ready_mode = 0;  // 0: always ready, 1: random, 2: never
    int          dly_lo = 0;
    int          dly_hi = 0;
    bit          mem_en = 1'b1;
    int          n_req  = 0;
    bit          pending = 1'b0;
    int          pend_dly = 0;
    logic [31:0] pend_addr = '0;
    bit          ovr_en = 1'b0;
    logic [31:0] ovr_data = '0;

    always begin : mem_model
        bit          fire;
        logic [31:0] fa;
        @(negedge clk);
        fire = rst && imem.req_valid && imem.req_ready;
        fa   = imem.addr;
        @(posedge clk);
        #1;
        if (!rst) begin
            pending = 1'b0;
        end
        if (mem_en) begin
            imem.rsp_valid = 1'b0;
            imem.rsp_err   = 1'b0;
            imem.rsp_data  = '0;
            if (fire) begin
                n_req++;
                pending   = 1'b1;
                pend_addr = fa;
                pend_dly  = int'($urandom_range(dly_hi, dly_lo));
            end
            if (pending && pend_dly == 0) begin
                imem.rsp_valid = 1'b1;
                if (ovr_en) begin
                    imem.rsp_data = ovr_data;
                    imem.rsp_err  = 1'b0;
                    ovr_en        = 1'b0;
                end else begin
                    imem.rsp_data = mem_data(pend_addr);
                    imem.rsp_err  = mem_err(pend_addr);
                end
                pending = 1'b0;
            end else if (pending) begin
                pend_dly--;
            end
            case (mem_ready_mode)
                0:       imem.req_ready = 1'b1;
                1:       imem.req_ready = 1'($urandom_range(0, 1));
                default: imem.req_ready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard ----------------
    logic [DATA_W:0] exp_q[$];   // {inst_err, inst}
    int              exp_cnt = 0;

    // One fetch: pc_valid for one cycle, optional flush at cycle flush_at
    // (0 = together with pc_valid). Any flush before the delivery is taken
    // discards the fetch.
    task automatic run_txn(input logic [31:0] p, input int flush_at);
        bit              flushed;
        bit              done;
        bit              aligned;
        int              req0;
        int              exp_req;
        logic [31:0]     wa;
        logic [DATA_W:0] e;
        aligned = (p[1:0] == 2'b00);
        wa      = {p[31:2], 2'b00};
        if (!aligned)          e = {1'b1, 32'h0};
        else if (ovr_en)       e = {1'b0, ovr_data};
        else if (mem_err(wa))  e = {1'b1, 32'h0};
        else                   e = {1'b0, mem_data(wa)};
        exp_q.push_back(e);
        exp_req = (aligned && flush_at != 0) ? 1 : 0;
        req0    = n_req;
        flushed = 1'b0;
        done    = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(posedge clk);
            #1;
            pc_valid   = (c == 0);
            pc         = (c == 0) ? p : $urandom();
            flush      = (c == flush_at);
            inst_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (imem.req_valid) check_val("req_addr", imem.addr, wa);
            if (inst_valid) begin
                if (flushed) begin
                    check_val("dropped_presented", inst_valid, 0);
                end else begin
                    check_val("inst", inst, exp_q[0][31:0]);
                    check_val("inst_err", inst_err, exp_q[0][32]);
                    if (inst_ready && !flush) begin
                        void'(exp_q.pop_front());
                        exp_cnt++;
                        done = 1'b1;
                    end
                end
            end
            if (flush) flushed = 1'b1;
            if (flushed && !imem.req_valid && !pending && !imem.rsp_valid) done = 1'b1;
        end
        check_val("txn_done", done, 1);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clk);
        #1;
        pc_valid   = 1'b0;
        flush      = 1'b0;
        inst_ready = 1'b0;
        @(negedge clk);
        check_val("fetch_cnt", fetch_cnt, exp_cnt);
        check_val("req_count", 64'(n_req - req0), 64'(exp_req));
        check_val("idle_no_valid", inst_valid, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int          req0;
        logic [31:0] rp;
        int          fa;
        bit          seen;

        rst            = 1'b0;
        pc             = '0;
        pc_valid       = 1'b0;
        flush          = 1'b0;
        inst_ready     = 1'b0;
        imem.req_ready = 1'b1;
        imem.rsp_valid = 1'b0;
        imem.rsp_data  = '0;
        imem.rsp_err   = 1'b0;

        // Test 1: reset, then 10 idle cycles.
        #23;
        rst = 1'b1;
        @(negedge clk);
        check_val("rst_inst", inst, 0);
        check_val("rst_inst_valid", inst_valid, 0);
        check_val("rst_inst_err", inst_err, 0);
        check_val("rst_addr", imem.addr, 0);
        check_val("rst_fetch_cnt", fetch_cnt, 0);
        check_val("rst_state_idle", state_dbg, 0);
        for (int i = 0; i < 10; i++) begin
            check_val("rst_no_req", imem.req_valid, 0);
            @(negedge clk);
        end

        // Test 2: basic fetch with zero-wait memory.
        mem_ready_mode = 0;
        dly_lo = 0;
        dly_hi = 0;
        ovr_en = 1'b1;
        ovr_data = 32'h0010_0073;
        @(posedge clk); #1;
        pc = 32'h8000_0000;
        pc_valid = 1'b1;
        @(negedge clk);
        check_val("lat_c0_req", imem.req_valid, 0);
        @(posedge clk); #1;
        pc_valid = 1'b0;
        @(negedge clk);
        check_val("lat_c1_req", imem.req_valid, 1);
        check_val("lat_c1_addr", imem.addr, 32'h8000_0000);
        @(negedge clk);
        check_val("lat_c2_req", imem.req_valid, 0);
        check_val("lat_c2_valid", inst_valid, 0);
        @(posedge clk); #1;
        inst_ready = 1'b1;
        @(negedge clk);
        check_val("lat_c3_valid", inst_valid, 1);
        check_val("lat_c3_inst", inst, 32'h0010_0073);
        check_val("lat_c3_err", inst_err, 0);
        @(posedge clk); #1;
        inst_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check_val("lat_c4_cnt", fetch_cnt, exp_cnt);
        check_val("lat_c4_valid", inst_valid, 0);

        // Test 3: memory and core backpressure.
        mem_ready_mode = 2;
        req0 = n_req;
        @(posedge clk); #1;
        pc = 32'h8000_0040;
        pc_valid = 1'b1;
        @(posedge clk); #1;
        pc_valid = 1'b0;
        pc = $urandom();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val("bp_req_held", imem.req_valid, 1);
            check_val("bp_addr_held", imem.addr, 32'h8000_0040);
        end
        mem_ready_mode = 0;
        for (int i = 0; i < 20 && !inst_valid; i++) @(negedge clk);
        check_val("bp_inst_valid", inst_valid, 1);
        for (int i = 0; i < 3; i++) begin
            check_val("bp_inst_held", inst, mem_data(32'h8000_0040));
            check_val("bp_valid_held", inst_valid, 1);
            @(negedge clk);
        end
        @(posedge clk); #1;
        inst_ready = 1'b1;
        @(negedge clk);
        check_val("bp_inst_take", inst, mem_data(32'h8000_0040));
        @(posedge clk); #1;
        inst_ready = 1'b0;
        exp_cnt++;
        @(negedge clk);
        check_val("bp_cnt", fetch_cnt, exp_cnt);
        check_val("bp_single_req", 64'(n_req - req0), 1);

        // Test 4: misaligned pc and memory error.
        mem_ready_mode = 1;
        dly_hi = 2;
        run_txn(32'h8000_0002, NO_FLUSH);
        run_txn(32'h8000_0004, NO_FLUSH);

        // Test 5: flush while waiting for the response.
        mem_ready_mode = 0;
        dly_lo = 3;
        dly_hi = 3;
        ovr_en = 1'b1;
        ovr_data = 32'hDEAD_BEEF;
        run_txn(32'h8000_0010, 2);
        dly_lo = 0;
        dly_hi = 0;
        run_txn(32'h8000_0008, NO_FLUSH);

        // Randomized fetches with random flushes and backpressure.
        mem_ready_mode = 1;
        dly_lo = 0;
        dly_hi = 2;
        for (int t = 0; t < 60; t++) begin
            rp = 32'h8000_0000 | (32'($urandom_range(0, 255)) << 2);
            if ($urandom_range(0, 5) == 0) rp[1:0] = 2'($urandom_range(1, 3));
            fa = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, 6)) : NO_FLUSH;
            run_txn(rp, fa);
        end

        // Test 6: asynchronous reset while waiting for a response.
        mem_en = 1'b0;
        imem.rsp_valid = 1'b0;
        imem.req_ready = 1'b1;
        @(posedge clk); #1;
        pc = 32'h8000_0080;
        pc_valid = 1'b1;
        @(posedge clk); #1;
        pc_valid = 1'b0;
        @(posedge clk); #1;
        #2;
        rst = 1'b0;
        exp_cnt = 0;
        #1;
        check_val("arst_cnt", fetch_cnt, 0);
        check_val("arst_addr", imem.addr, 0);
        check_val("arst_req", imem.req_valid, 0);
        check_val("arst_valid", inst_valid, 0);
        check_val("arst_inst", inst, 0);
        check_val("arst_err", inst_err, 0);
        @(posedge clk); #3;
        rst = 1'b1;
        @(posedge clk); #1;
        imem.rsp_valid = 1'b1;
        imem.rsp_data  = 32'h1234_5678;
        @(posedge clk); #1;
        imem.rsp_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (inst_valid || imem.req_valid) seen = 1'b1;
        end
        check_val("late_rsp_ignored", seen, 0);
        check_val("late_rsp_cnt", fetch_cnt, exp_cnt);

        // Recovery after reset.
        mem_en = 1'b1;
        for (int t = 0; t < 8; t++) begin
            rp = 32'h8000_0100 | (32'($urandom_range(0, 63)) << 2);
            run_txn(rp, NO_FLUSH);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
